// File: rtl/qdr_pkg.sv
// rtl/qdr_pkg.sv - shared constants and width helpers for the QDR II+ user-port arbiter
//
// Contents:
//   BL4                     burst length of the QDR II+ user interface
//   DEF_*                   default widths/depths used by qdr_arbiter
//   port_idx_width(n)       bits needed to index n items (never less than 1)

package qdr_pkg;

    localparam int BL4 = 4;

    localparam int DEF_NUM_PORTS  = 2;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = BL4 * 36;
    localparam int DEF_BW_WIDTH   = BL4 * 4;
    localparam int DEF_MAX_RD_OUT = 16;

    // A single requester still needs a 1-bit index so vectors never collapse to zero width.
    function automatic int port_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/qdr_tag_fifo.sv
// rtl/qdr_tag_fifo.sv - in-order FIFO of requester indices for outstanding reads
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   push, push_data     enqueue one tag (ignored while full)
//   pop                 dequeue the head tag (ignored while empty)
//   head                tag at the head of the queue
//   count               current occupancy, 0..DEPTH
//   full, empty         occupancy flags

module qdr_tag_fifo
    import qdr_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = port_idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/qdr_arbiter.sv
// rtl/qdr_arbiter.sv - round-robin sharing of one QDR II+ controller user port between requesters
//
// Ports:
//   sys_clk, sys_rst                 user clock, synchronous active-high reset
//   init_calib_complete              no grants are issued until the controller is calibrated
//   req_wr_valid/ready/addr/data/bw_n  per-port write requests (packed, port i at slice i)
//   req_rd_valid/ready/addr          per-port read requests (packed)
//   rsp_rd_valid, rsp_rd_data        one-hot read-return strobe and shared read data
//   app_wr_cmd/addr/data/bw_n        registered controller write command
//   app_rd_cmd/addr                  registered controller read command
//   app_rd_valid, app_rd_data        controller read return
//   rd_outstanding                   reads issued but not yet returned
//   rd_err                           sticky: a read returned with nothing outstanding

module qdr_arbiter
    import qdr_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BW_WIDTH   = DEF_BW_WIDTH,
    parameter int MAX_RD_OUT = DEF_MAX_RD_OUT
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            init_calib_complete,

    input  logic [NUM_PORTS-1:0]            req_wr_valid,
    output logic [NUM_PORTS-1:0]            req_wr_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_wr_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wr_data,
    input  logic [NUM_PORTS*BW_WIDTH-1:0]   req_wr_bw_n,

    input  logic [NUM_PORTS-1:0]            req_rd_valid,
    output logic [NUM_PORTS-1:0]            req_rd_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_rd_addr,

    output logic [NUM_PORTS-1:0]            rsp_rd_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rd_data,

    output logic                            app_wr_cmd,
    output logic [ADDR_WIDTH-1:0]           app_wr_addr,
    output logic [DATA_WIDTH-1:0]           app_wr_data,
    output logic [BW_WIDTH-1:0]             app_wr_bw_n,
    output logic                            app_rd_cmd,
    output logic [ADDR_WIDTH-1:0]           app_rd_addr,
    input  logic                            app_rd_valid,
    input  logic [DATA_WIDTH-1:0]           app_rd_data,

    output logic [$clog2(MAX_RD_OUT):0]     rd_outstanding,
    output logic                            rd_err
);

    localparam int PW = port_idx_width(NUM_PORTS);
    localparam int CW = $clog2(MAX_RD_OUT) + 1;
    localparam logic [NUM_PORTS-1:0] PORT_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    // First eligible port at or above ptr, wrapping to the lowest eligible port.
    function automatic logic [NUM_PORTS-1:0] rr_grant(input logic [NUM_PORTS-1:0] elig,
                                                      input logic [PW-1:0]        ptr);
        logic [NUM_PORTS-1:0] at_or_above;
        logic [NUM_PORTS-1:0] upper;
        logic [NUM_PORTS-1:0] pick;
        for (int i = 0; i < NUM_PORTS; i++) begin
            at_or_above[i] = (i >= int'(ptr));
        end
        upper = elig & at_or_above;
        pick  = (upper != '0) ? upper : elig;
        // Isolate the lowest set bit.
        return pick & (~pick + PORT_ONE);
    endfunction

    function automatic logic [PW-1:0] gnt_index(input logic [NUM_PORTS-1:0] gnt);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_PORTS - 1)) ? '0 : idx + PW'(1);
    endfunction

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [NUM_PORTS-1:0]  wr_elig, rd_elig;
    logic [NUM_PORTS-1:0]  wr_gnt, rd_gnt;
    logic [PW-1:0]         wr_idx, rd_idx;
    logic                  wr_fire, rd_fire;

    logic                  tag_pop;
    logic [PW-1:0]         tag_head;
    logic [CW-1:0]         tag_count;
    logic                  tag_full, tag_empty;

    logic                  app_wr_cmd_q, app_wr_cmd_d;
    logic [ADDR_WIDTH-1:0] app_wr_addr_q, app_wr_addr_d;
    logic [DATA_WIDTH-1:0] app_wr_data_q, app_wr_data_d;
    logic [BW_WIDTH-1:0]   app_wr_bw_n_q, app_wr_bw_n_d;
    logic                  app_rd_cmd_q, app_rd_cmd_d;
    logic [ADDR_WIDTH-1:0] app_rd_addr_q, app_rd_addr_d;
    logic [NUM_PORTS-1:0]  rsp_rd_valid_q, rsp_rd_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rd_data_q, rsp_rd_data_d;
    logic                  rd_err_q, rd_err_d;

    // Reads are also held off while every tag slot is in use; a same-cycle
    // return only frees its slot on the following cycle.
    assign wr_elig = req_wr_valid & {NUM_PORTS{init_calib_complete}};
    assign rd_elig = req_rd_valid & {NUM_PORTS{init_calib_complete & ~tag_full}};

    assign wr_gnt  = sys_rst ? '0 : rr_grant(wr_elig, wr_ptr_q);
    assign rd_gnt  = sys_rst ? '0 : rr_grant(rd_elig, rd_ptr_q);
    assign wr_idx  = gnt_index(wr_gnt);
    assign rd_idx  = gnt_index(rd_gnt);
    assign wr_fire = |wr_gnt;
    assign rd_fire = |rd_gnt;

    assign req_wr_ready = wr_gnt;
    assign req_rd_ready = rd_gnt;

    // Returns with no outstanding tag are dropped rather than routed.
    assign tag_pop = app_rd_valid & ~tag_empty;

    qdr_tag_fifo #(
        .WIDTH (PW),
        .DEPTH (MAX_RD_OUT)
    ) u_tag_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (rd_fire),
        .push_data (rd_idx),
        .pop       (tag_pop),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        app_wr_cmd_d   = wr_fire;
        app_wr_addr_d  = app_wr_addr_q;
        app_wr_data_d  = app_wr_data_q;
        app_wr_bw_n_d  = app_wr_bw_n_q;
        app_rd_cmd_d   = rd_fire;
        app_rd_addr_d  = app_rd_addr_q;
        rsp_rd_valid_d = '0;
        rsp_rd_data_d  = rsp_rd_data_q;
        rd_err_d       = rd_err_q | (app_rd_valid & tag_empty);

        if (wr_fire) wr_ptr_d = next_ptr(wr_idx);
        if (rd_fire) rd_ptr_d = next_ptr(rd_idx);

        // Grants are one-hot, so at most one slice is selected.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_gnt[i]) begin
                app_wr_addr_d = req_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                app_wr_data_d = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                app_wr_bw_n_d = req_wr_bw_n[i*BW_WIDTH +: BW_WIDTH];
            end
            if (rd_gnt[i]) begin
                app_rd_addr_d = req_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
            rsp_rd_valid_d[i] = tag_pop && (tag_head == PW'(i));
        end

        if (tag_pop) rsp_rd_data_d = app_rd_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            app_wr_cmd_q   <= 1'b0;
            app_wr_addr_q  <= '0;
            app_wr_data_q  <= '0;
            app_wr_bw_n_q  <= '1;
            app_rd_cmd_q   <= 1'b0;
            app_rd_addr_q  <= '0;
            rsp_rd_valid_q <= '0;
            rsp_rd_data_q  <= '0;
            rd_err_q       <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            app_wr_cmd_q   <= app_wr_cmd_d;
            app_wr_addr_q  <= app_wr_addr_d;
            app_wr_data_q  <= app_wr_data_d;
            app_wr_bw_n_q  <= app_wr_bw_n_d;
            app_rd_cmd_q   <= app_rd_cmd_d;
            app_rd_addr_q  <= app_rd_addr_d;
            rsp_rd_valid_q <= rsp_rd_valid_d;
            rsp_rd_data_q  <= rsp_rd_data_d;
            rd_err_q       <= rd_err_d;
        end
    end

    assign app_wr_cmd     = app_wr_cmd_q;
    assign app_wr_addr    = app_wr_addr_q;
    assign app_wr_data    = app_wr_data_q;
    assign app_wr_bw_n    = app_wr_bw_n_q;
    assign app_rd_cmd     = app_rd_cmd_q;
    assign app_rd_addr    = app_rd_addr_q;
    assign rsp_rd_valid   = rsp_rd_valid_q;
    assign rsp_rd_data    = rsp_rd_data_q;
    assign rd_outstanding = tag_count;
    assign rd_err         = rd_err_q;

endmodule

// File: tb/tb_qdr_arbiter.sv
// tb/tb_qdr_arbiter.sv - scoreboard bench for qdr_arbiter with directed stimulus

module tb_qdr_arbiter;

    localparam int NP = 2;
    localparam int AW = 10;
    localparam int DW = 144;
    localparam int BW = 16;
    localparam int MO = 16;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst;
    logic                 init_calib_complete;
    logic [NP-1:0]        req_wr_valid, req_wr_ready;
    logic [NP*AW-1:0]     req_wr_addr;
    logic [NP*DW-1:0]     req_wr_data;
    logic [NP*BW-1:0]     req_wr_bw_n;
    logic [NP-1:0]        req_rd_valid, req_rd_ready;
    logic [NP*AW-1:0]     req_rd_addr;
    logic [NP-1:0]        rsp_rd_valid;
    logic [DW-1:0]        rsp_rd_data;
    logic                 app_wr_cmd;
    logic [AW-1:0]        app_wr_addr;
    logic [DW-1:0]        app_wr_data;
    logic [BW-1:0]        app_wr_bw_n;
    logic                 app_rd_cmd;
    logic [AW-1:0]        app_rd_addr;
    logic                 app_rd_valid;
    logic [DW-1:0]        app_rd_data;
    logic [$clog2(MO):0]  rd_outstanding;
    logic                 rd_err;

    qdr_arbiter #(
        .NUM_PORTS (NP), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BW_WIDTH (BW), .MAX_RD_OUT (MO)
    ) dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .init_calib_complete (init_calib_complete),
        .req_wr_valid        (req_wr_valid),
        .req_wr_ready        (req_wr_ready),
        .req_wr_addr         (req_wr_addr),
        .req_wr_data         (req_wr_data),
        .req_wr_bw_n         (req_wr_bw_n),
        .req_rd_valid        (req_rd_valid),
        .req_rd_ready        (req_rd_ready),
        .req_rd_addr         (req_rd_addr),
        .rsp_rd_valid        (rsp_rd_valid),
        .rsp_rd_data         (rsp_rd_data),
        .app_wr_cmd          (app_wr_cmd),
        .app_wr_addr         (app_wr_addr),
        .app_wr_data         (app_wr_data),
        .app_wr_bw_n         (app_wr_bw_n),
        .app_rd_cmd          (app_rd_cmd),
        .app_rd_addr         (app_rd_addr),
        .app_rd_valid        (app_rd_valid),
        .app_rd_data         (app_rd_data),
        .rd_outstanding      (rd_outstanding),
        .rd_err              (rd_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; logic [BW-1:0] bw; } wr_exp_t;
    typedef struct { int cyc; logic [AW-1:0] addr; } rd_exp_t;
    typedef struct { int cyc; int port; logic [DW-1:0] data; } rsp_exp_t;

    wr_exp_t  wr_q[$];
    rd_exp_t  rd_q[$];
    rsp_exp_t rsp_q[$];
    int       iss_q[$];
    logic     exp_err = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int step_no = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [AW-1:0] waddr(input int p, input int s);
        return AW'((p << 8) | (s & 127));
    endfunction
    function automatic logic [AW-1:0] raddr(input int p, input int s);
        return AW'((p << 8) | 128 | (s & 127));
    endfunction
    function automatic logic [DW-1:0] wdata(input int p, input int s);
        return {8'(p + 1), 16'(s), {15{8'h5A}}};
    endfunction
    function automatic logic [BW-1:0] wbw(input int p, input int s);
        return BW'((s << 4) | p);
    endfunction
    function automatic logic [DW-1:0] rdat(input int k);
        return {16'(k), {15{8'h3C}}, 8'hA5};
    endfunction
    function automatic int oh_idx(input logic [NP-1:0] v);
        return v[1] ? 1 : 0;
    endfunction

    // Monitor: every cycle, each output channel either matches the queued expectation due now or is idle.
    wr_exp_t  mw;
    rd_exp_t  mr;
    rsp_exp_t ms;
    always @(negedge sys_clk) begin
        if (wr_q.size() != 0 && wr_q[0].cyc == cyc) begin
            mw = wr_q.pop_front();
            chk("app_wr_cmd", 160'(app_wr_cmd), 160'(1));
            chk("app_wr_addr", 160'(app_wr_addr), 160'(mw.addr));
            chk("app_wr_data", 160'(app_wr_data), 160'(mw.data));
            chk("app_wr_bw_n", 160'(app_wr_bw_n), 160'(mw.bw));
        end else begin
            chk("app_wr_cmd_idle", 160'(app_wr_cmd), 160'(0));
        end
        if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
            mr = rd_q.pop_front();
            chk("app_rd_cmd", 160'(app_rd_cmd), 160'(1));
            chk("app_rd_addr", 160'(app_rd_addr), 160'(mr.addr));
        end else begin
            chk("app_rd_cmd_idle", 160'(app_rd_cmd), 160'(0));
        end
        if (rsp_q.size() != 0 && rsp_q[0].cyc == cyc) begin
            ms = rsp_q.pop_front();
            chk("rsp_rd_valid", 160'(rsp_rd_valid), 160'(NP'(1) << ms.port));
            chk("rsp_rd_data", 160'(rsp_rd_data), 160'(ms.data));
        end else begin
            chk("rsp_rd_valid_idle", 160'(rsp_rd_valid), 160'(0));
        end
    end

    // One cycle of stimulus: drive, check combinational ready and status, queue expectations.
    task automatic step(input logic rst, input logic cal, input logic [NP-1:0] wv, input logic [NP-1:0] rv,
                        input logic [NP-1:0] exp_wr, input logic [NP-1:0] exp_rd,
                        input logic av, input logic [DW-1:0] ad);
        int p;
        sys_rst             = rst;
        init_calib_complete = cal;
        req_wr_valid        = wv;
        req_rd_valid        = rv;
        for (int i = 0; i < NP; i++) begin
            req_wr_addr[i*AW +: AW] = waddr(i, step_no);
            req_wr_data[i*DW +: DW] = wdata(i, step_no);
            req_wr_bw_n[i*BW +: BW] = wbw(i, step_no);
            req_rd_addr[i*AW +: AW] = raddr(i, step_no);
        end
        app_rd_valid = av;
        app_rd_data  = ad;
        #1;
        chk("req_wr_ready", 160'(req_wr_ready), 160'(exp_wr));
        chk("req_rd_ready", 160'(req_rd_ready), 160'(exp_rd));
        chk("rd_outstanding", 160'(rd_outstanding), 160'(iss_q.size()));
        chk("rd_err", 160'(rd_err), 160'(exp_err));
        if (rst) begin
            iss_q.delete();
            exp_err = 1'b0;
        end else begin
            if (av) begin
                if (iss_q.size() != 0) begin
                    p = iss_q.pop_front();
                    rsp_q.push_back('{cyc + 1, p, ad});
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (exp_wr != '0) begin
                p = oh_idx(exp_wr);
                wr_q.push_back('{cyc + 1, waddr(p, step_no), wdata(p, step_no), wbw(p, step_no)});
            end
            if (exp_rd != '0) begin
                p = oh_idx(exp_rd);
                rd_q.push_back('{cyc + 1, raddr(p, step_no)});
                iss_q.push_back(p);
            end
        end
        @(negedge sys_clk);
        step_no++;
    endtask

    initial begin
        sys_rst = 1'b1; init_calib_complete = 1'b0;
        req_wr_valid = '0; req_rd_valid = '0;
        req_wr_addr = '0; req_wr_data = '0; req_wr_bw_n = '1; req_rd_addr = '0;
        app_rd_valid = 1'b0; app_rd_data = '0;
        @(negedge sys_clk);

        // Reset held with requests pending: nothing may be granted.
        for (int k = 0; k < 3; k++) step(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, '0);
        chk("rst_app_wr_bw_n", 160'(app_wr_bw_n), 160'(16'hFFFF));
        chk("rst_app_wr_addr", 160'(app_wr_addr), 160'(0));
        chk("rst_app_wr_data", 160'(app_wr_data), 160'(0));
        chk("rst_app_rd_addr", 160'(app_rd_addr), 160'(0));
        chk("rst_rsp_rd_data", 160'(rsp_rd_data), 160'(0));

        // Calibration low: no grants.
        for (int k = 0; k < 2; k++) step(0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 0, '0);

        // Calibration rises: writes alternate 0,1,0,1,0,1.
        for (int k = 0; k < 6; k++) step(0, 1, 2'b11, 2'b00, (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 0, '0);

        // Write on port 0 and read on port 1 in the same cycle, then its return.
        step(0, 1, 2'b01, 2'b10, 2'b01, 2'b10, 0, '0);
        step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, rdat(1));

        // Fill all 16 tag slots with returns stalled.
        for (int k = 0; k < 16; k++) step(0, 1, 2'b00, 2'b11, 2'b00, (k % 2 == 0) ? 2'b01 : 2'b10, 0, '0);
        step(0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 0, '0);
        chk("full_count", 160'(rd_outstanding), 160'(16));
        chk("full_rd_ready", 160'(req_rd_ready), 160'(0));
        // Return while full: still no grant this cycle.
        step(0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 1, rdat(2));
        // Push and pop together, then refill the last slot.
        step(0, 1, 2'b00, 2'b11, 2'b00, 2'b01, 1, rdat(3));
        step(0, 1, 2'b00, 2'b11, 2'b00, 2'b10, 0, '0);
        step(0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 0, '0);
        chk("refill_count", 160'(rd_outstanding), 160'(16));

        // Calibration drops: no new grants, outstanding reads still drain in order.
        for (int k = 0; k < 16; k++) step(0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 1, rdat(k + 4));
        chk("drained_count", 160'(rd_outstanding), 160'(0));

        // Return with nothing outstanding.
        step(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, rdat(40));
        step(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, '0);
        step(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, '0);
        chk("rd_err_sticky", 160'(rd_err), 160'(1));

        // Five reads outstanding (and a write to move the write pointer), then reset.
        step(0, 1, 2'b01, 2'b01, 2'b01, 2'b01, 0, '0);
        for (int k = 0; k < 4; k++) step(0, 1, 2'b00, 2'b01, 2'b00, 2'b01, 0, '0);
        chk("pre_rst_count", 160'(rd_outstanding), 160'(5));
        step(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, '0);
        chk("post_rst_count", 160'(rd_outstanding), 160'(0));
        chk("post_rst_rd_err", 160'(rd_err), 160'(0));
        // Late return after reset, then both pointers must start from port 0.
        step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, rdat(50));
        step(0, 1, 2'b11, 2'b11, 2'b01, 2'b01, 0, '0);
        step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, rdat(51));
        step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, '0);
        step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, '0);

        chk("wr_q_drained", 160'(wr_q.size()), 160'(0));
        chk("rd_q_drained", 160'(rd_q.size()), 160'(0));
        chk("rsp_q_drained", 160'(rsp_q.size()), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
